// File: rtl/alu_branch_exec.sv
// Registered execute stage for a single-cycle MIPS-style datapath.
// Contains the ALU, the zero flag, the BEQ/BNE branch decision, and the PC+4 adder.
// It also selects between the sequential PC and the branch target.
// Every output comes from a single register stage.
module alu_branch_exec #(
  parameter int DATA_W = 32,
  parameter int PC_INC = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic [3:0]        alu_ctrl,
  input  logic [1:0]        branch,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic [DATA_W-1:0] pc_plus4,
  output logic              br_taken,
  output logic [DATA_W-1:0] pc_next
);

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_NOR  = 4'b1100
  } alu_op_e;

  logic [4:0]        shamt;
  logic [DATA_W-1:0] alu_r;
  logic              alu_zero;
  logic              br_dec;
  logic [DATA_W-1:0] seq_pc;
  logic [DATA_W-1:0] target_pc;
  logic [DATA_W-1:0] sel_pc;

  logic              out_valid_d, out_valid_q;
  logic [DATA_W-1:0] alu_out_d, alu_out_q;
  logic              zero_d, zero_q;
  logic [DATA_W-1:0] pc_plus4_d, pc_plus4_q;
  logic              br_taken_d, br_taken_q;
  logic [DATA_W-1:0] pc_next_d, pc_next_q;

  // ALU, zero flag, branch AND gate and next-PC selection (combinational)
  always_comb begin
    shamt = op_a[4:0];
    alu_r = '0;
    case (alu_op_e'(alu_ctrl))
      ALU_AND:  alu_r = op_a & op_b;
      ALU_OR:   alu_r = op_a | op_b;
      ALU_ADD:  alu_r = op_a + op_b;
      ALU_XOR:  alu_r = op_a ^ op_b;
      ALU_SLL:  alu_r = op_b << shamt;
      ALU_SRL:  alu_r = op_b >> shamt;
      ALU_SUB:  alu_r = op_a - op_b;
      ALU_SLT:  alu_r = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SRA:  alu_r = $signed(op_b) >>> shamt;
      ALU_SLTU: alu_r = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      ALU_NOR:  alu_r = ~(op_a | op_b);
      default:  alu_r = '0;
    endcase
    alu_zero  = (alu_r == '0);
    br_dec    = branch[1] & (branch[0] ? alu_zero : ~alu_zero);
    seq_pc    = pc + DATA_W'(PC_INC);
    target_pc = seq_pc + (imm_ext << 2);
    sel_pc    = br_dec ? target_pc : seq_pc;
  end

  // Load a new result only when the input is valid; otherwise keep the previous outputs
  always_comb begin
    out_valid_d = in_valid;
    alu_out_d   = alu_out_q;
    zero_d      = zero_q;
    pc_plus4_d  = pc_plus4_q;
    br_taken_d  = br_taken_q;
    pc_next_d   = pc_next_q;
    if (in_valid) begin
      alu_out_d  = alu_r;
      zero_d     = alu_zero;
      pc_plus4_d = seq_pc;
      br_taken_d = br_dec;
      pc_next_d  = sel_pc;
    end
  end

  // Output register stage with synchronous clear
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      zero_q      <= 1'b0;
      pc_plus4_q  <= '0;
      br_taken_q  <= 1'b0;
      pc_next_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      zero_q      <= zero_d;
      pc_plus4_q  <= pc_plus4_d;
      br_taken_q  <= br_taken_d;
      pc_next_q   <= pc_next_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_out   = alu_out_q;
  assign zero      = zero_q;
  assign pc_plus4  = pc_plus4_q;
  assign br_taken  = br_taken_q;
  assign pc_next   = pc_next_q;

endmodule

// File: tb/tb_alu_branch_exec.sv
// Testbench for alu_branch_exec.
// Uses directed scenarios plus randomized traffic.
// Expected outputs come from a behavioural model of the execute stage.
module tb_alu_branch_exec;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc, op_a, op_b, imm_ext;
  logic [3:0]  alu_ctrl;
  logic [1:0]  branch;
  logic        out_valid, zero, br_taken;
  logic [31:0] alu_out, pc_plus4, pc_next;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the registered outputs
  logic        m_valid, m_zero, m_taken;
  logic [31:0] m_alu, m_pc4, m_next;

  alu_branch_exec #(.DATA_W(32), .PC_INC(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .pc(pc), .op_a(op_a),
    .op_b(op_b), .imm_ext(imm_ext), .alu_ctrl(alu_ctrl), .branch(branch),
    .out_valid(out_valid), .alu_out(alu_out), .zero(zero), .pc_plus4(pc_plus4),
    .br_taken(br_taken), .pc_next(pc_next)
  );

  always #5 clock = ~clock;

  // Reference ALU written from the operation table with plain arithmetic
  function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    sh = a % 32;
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a ^ b;
      4'd4:  return b << sh;
      4'd5:  return b >> sh;
      4'd6:  return a - b;
      4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:  return b[31] ? ~((~b) >> sh) : (b >> sh);
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, sample 1ns later
  task automatic cycle(input logic r, input logic v, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] p,
                       input logic [31:0] imm, input logic [1:0] br);
    logic [31:0] res, pc4;
    logic        tk;
    reset = r; in_valid = v; alu_ctrl = op; op_a = a; op_b = b; pc = p;
    imm_ext = imm; branch = br;
    @(posedge clock);
    res = model_alu(op, a, b);
    pc4 = p + 32'd4;
    tk  = (br == 2'b11 && res == 0) || (br == 2'b10 && res != 0);
    if (r) begin
      m_valid = 0; m_alu = 0; m_zero = 0; m_pc4 = 0; m_taken = 0; m_next = 0;
    end else begin
      m_valid = v;
      if (v) begin
        m_alu = res; m_zero = (res == 0); m_pc4 = pc4; m_taken = tk;
        m_next = tk ? pc4 + imm * 32'd4 : pc4;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 1, OP_ADD, 32'd5, 32'd3, 32'h10, 32'd1, 2'b11);
    cycle(1, 1, OP_ADD, 32'd5, 32'd3, 32'h10, 32'd1, 2'b11);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (alu_out !== 32'd0) begin n_fail++; $display("FAIL reset_alu: got %h expected 0", alu_out); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b expected 0", zero); end
    n_checks++; if (pc_plus4 !== 32'd0) begin n_fail++; $display("FAIL reset_pc4: got %h expected 0", pc_plus4); end
    n_checks++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b expected 0", br_taken); end
    n_checks++; if (pc_next !== 32'd0) begin n_fail++; $display("FAIL reset_next: got %h expected 0", pc_next); end
    cycle(0, 1, OP_ADD, 32'd5, 32'd3, 32'h10, 32'd0, 2'b00);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b expected 1", out_valid); end
    n_checks++; if (alu_out !== 32'd8) begin n_fail++; $display("FAIL first_add: got %h expected 8", alu_out); end
    n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL first_zero: got %b expected 0", zero); end
  endtask

  task automatic test_alu_sweep();
    logic [3:0]  ops [7] = '{OP_AND, OP_OR, OP_SUB, OP_SLT, OP_SLTU, OP_NOR, 4'b1111};
    logic [31:0] exp [7] = '{32'h0, 32'hFFFFFFFF, 32'h1F, 32'h0, 32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, ops[i], 32'h0000000F, 32'hFFFFFFF0, 32'h0, 32'h0, 2'b00);
      n_checks++;
      if (alu_out !== exp[i]) begin n_fail++; $display("FAIL sweep_op%0d: got %h expected %h", ops[i], alu_out, exp[i]); end
      n_checks++;
      if (zero !== (exp[i] == 32'h0)) begin n_fail++; $display("FAIL sweep_zero%0d: got %b expected %b", ops[i], zero, exp[i] == 32'h0); end
    end
  endtask

  task automatic test_beq();
    cycle(0, 1, OP_SUB, 32'd7, 32'd7, 32'h100, 32'h3, 2'b11);
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL beq_zero: got %b expected 1", zero); end
    n_checks++; if (br_taken !== 1'b1) begin n_fail++; $display("FAIL beq_taken: got %b expected 1", br_taken); end
    n_checks++; if (pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL beq_pc4: got %h expected 104", pc_plus4); end
    n_checks++; if (pc_next !== 32'h110) begin n_fail++; $display("FAIL beq_next: got %h expected 110", pc_next); end
    cycle(0, 1, OP_SUB, 32'd7, 32'd6, 32'h100, 32'h3, 2'b11);
    n_checks++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL beq_nt_taken: got %b expected 0", br_taken); end
    n_checks++; if (pc_next !== 32'h104) begin n_fail++; $display("FAIL beq_nt_next: got %h expected 104", pc_next); end
  endtask

  task automatic test_bne_backward();
    logic [1:0] nb [2] = '{2'b00, 2'b01};
    cycle(0, 1, OP_SUB, 32'd1, 32'd2, 32'h200, 32'hFFFFFFFE, 2'b10);
    n_checks++; if (br_taken !== 1'b1) begin n_fail++; $display("FAIL bne_taken: got %b expected 1", br_taken); end
    n_checks++; if (pc_next !== 32'h1FC) begin n_fail++; $display("FAIL bne_next: got %h expected 1fc", pc_next); end
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, OP_SUB, 32'd1, 32'd2, 32'h200, 32'hFFFFFFFE, nb[i]);
      n_checks++; if (br_taken !== 1'b0) begin n_fail++; $display("FAIL nobr%0d_taken: got %b expected 0", i, br_taken); end
      n_checks++; if (pc_next !== 32'h204) begin n_fail++; $display("FAIL nobr%0d_next: got %h expected 204", i, pc_next); end
    end
  endtask

  task automatic test_wrap();
    cycle(0, 1, OP_ADD, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFC, 32'h0, 2'b00);
    n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4: got %h expected 0", pc_plus4); end
    n_checks++; if (alu_out !== 32'h0) begin n_fail++; $display("FAIL wrap_add: got %h expected 0", alu_out); end
    n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL wrap_zero: got %b expected 1", zero); end
    cycle(0, 1, OP_SLL, 32'd4, 32'd1, 32'h0, 32'h0, 2'b00);
    n_checks++; if (alu_out !== 32'h10) begin n_fail++; $display("FAIL sll: got %h expected 10", alu_out); end
    cycle(0, 1, OP_SRA, 32'd4, 32'h80000000, 32'h0, 32'h0, 2'b00);
    n_checks++; if (alu_out !== 32'hF8000000) begin n_fail++; $display("FAIL sra: got %h expected f8000000", alu_out); end
  endtask

  task automatic test_valid_gap();
    cycle(0, 1, OP_ADD, 32'd2, 32'd3, 32'h40, 32'h0, 2'b00);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_v1: got %b expected 1", out_valid); end
    cycle(0, 0, 4'b0011, 32'hFF, 32'h0F, 32'h500, 32'h0, 2'b11);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_v0: got %b expected 0", out_valid); end
    n_checks++; if (alu_out !== 32'd5) begin n_fail++; $display("FAIL gap_hold_alu: got %h expected 5", alu_out); end
    n_checks++; if (pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL gap_hold_pc4: got %h expected 44", pc_plus4); end
    cycle(0, 1, 4'b0011, 32'hFF, 32'h0F, 32'h500, 32'h0, 2'b00);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_v2: got %b expected 1", out_valid); end
    n_checks++; if (alu_out !== 32'hF0) begin n_fail++; $display("FAIL gap_xor: got %h expected f0", alu_out); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, imm;
    for (int i = 0; i < 400; i++) begin
      a   = $urandom();
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom();
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 40);
      imm = 32'($urandom_range(0, 127)) - 32'd64;
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)),
            a, b, $urandom() & 32'hFFFFFFFC, imm, 2'($urandom_range(0, 3)));
      n_checks++; if (out_valid !== m_valid) begin n_fail++; $display("FAIL rnd%0d_valid: got %b expected %b", i, out_valid, m_valid); end
      n_checks++; if (alu_out !== m_alu) begin n_fail++; $display("FAIL rnd%0d_alu: got %h expected %h", i, alu_out, m_alu); end
      n_checks++; if (zero !== m_zero) begin n_fail++; $display("FAIL rnd%0d_zero: got %b expected %b", i, zero, m_zero); end
      n_checks++; if (pc_plus4 !== m_pc4) begin n_fail++; $display("FAIL rnd%0d_pc4: got %h expected %h", i, pc_plus4, m_pc4); end
      n_checks++; if (br_taken !== m_taken) begin n_fail++; $display("FAIL rnd%0d_taken: got %b expected %b", i, br_taken, m_taken); end
      n_checks++; if (pc_next !== m_next) begin n_fail++; $display("FAIL rnd%0d_next: got %h expected %h", i, pc_next, m_next); end
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; pc = 0; op_a = 0; op_b = 0; imm_ext = 0;
    alu_ctrl = 0; branch = 0;
    #2;
    test_reset();
    test_alu_sweep();
    test_beq();
    test_bne_backward();
    test_wrap();
    test_valid_gap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
